// File: rtl/reg_bypass_scoreboard.sv
// reg_bypass_scoreboard: multi-port operand forwarding with long-latency scoreboard and stall counter (in: rd_en/rd_addr/rf_rd_data, stg_*, lw_*, flush; out: rd_data/rf_rd_addr, hazard/stall/stall_cnt)
module reg_bypass_scoreboard #(
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_STAGE  = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_READ-1:0]             rd_en,
  input  logic [NUM_READ*REG_WIDTH-1:0]   rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ*REG_WIDTH-1:0]   rf_rd_addr,
  input  logic [NUM_READ*DATA_WIDTH-1:0]  rf_rd_data,
  input  logic [NUM_STAGE-1:0]            stg_wen,
  input  logic [NUM_STAGE*REG_WIDTH-1:0]  stg_waddr,
  input  logic [NUM_STAGE*DATA_WIDTH-1:0] stg_wdata,
  input  logic [NUM_STAGE-1:0]            stg_wvalid,
  input  logic                            lw_issue,
  input  logic [REG_WIDTH-1:0]            lw_issue_addr,
  input  logic                            lw_done,
  input  logic [REG_WIDTH-1:0]            lw_done_addr,
  output logic [NUM_READ-1:0]             hazard,
  output logic                            stall,
  output logic [CNT_WIDTH-1:0]            stall_cnt
);
  localparam int NREGS = 2**REG_WIDTH;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  assign rf_rd_addr = rd_addr;
  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [REG_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    logic hz;
    logic act;
    assign a = rd_addr[p*REG_WIDTH +: REG_WIDTH];
    assign act = rd_en[p] && (a != '0);
    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
      d = rf_rd_data[p*DATA_WIDTH +: DATA_WIDTH];
      hz = pending_q[a];
      for (int s = NUM_STAGE-1; s >= 0; s--)
        if (stg_wen[s] && stg_waddr[s*REG_WIDTH +: REG_WIDTH] == a) begin
          hz = !stg_wvalid[s];
          d = stg_wvalid[s] ? stg_wdata[s*DATA_WIDTH +: DATA_WIDTH] : rf_rd_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = act ? d : '0;
    assign hazard[p] = act && hz;
  end
  assign stall = |hazard;
  assign stall_cnt = stall_cnt_q;
  always_comb begin
    pending_d = pending_q;
    if (lw_done) pending_d[lw_done_addr] = 1'b0;
    if (lw_issue) pending_d[lw_issue_addr] = 1'b1;
    pending_d[0] = 1'b0;
    if (flush) pending_d = '0;
    stall_cnt_d = (stall && !flush && !(&stall_cnt_q)) ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_reg_bypass_scoreboard.sv
// tb_reg_bypass_scoreboard: directed stimulus against a behavioural forwarding/scoreboard model
module tb_reg_bypass_scoreboard;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [1:0] rd_en = '0;
  logic [9:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [9:0] rf_rd_addr;
  logic [63:0] rf_rd_data = '0;
  logic [2:0] stg_wen = '0, stg_wvalid = '0;
  logic [14:0] stg_waddr = '0;
  logic [95:0] stg_wdata = '0;
  logic lw_issue = 1'b0, lw_done = 1'b0;
  logic [4:0] lw_issue_addr = '0, lw_done_addr = '0;
  logic [1:0] hazard;
  logic stall;
  logic [3:0] stall_cnt;
  int n_chk = 0, n_fail = 0;
  bit [31:0] m_pend = '0;
  int m_cnt = 0;
  reg_bypass_scoreboard #(.CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .stg_wen(stg_wen), .stg_waddr(stg_waddr),
    .stg_wdata(stg_wdata), .stg_wvalid(stg_wvalid), .lw_issue(lw_issue), .lw_issue_addr(lw_issue_addr),
    .lw_done(lw_done), .lw_done_addr(lw_done_addr), .hazard(hazard), .stall(stall), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void exp_port(int p, output logic [31:0] d, output bit h);
    int a = int'(rd_addr[p*5 +: 5]);
    d = '0;
    h = 1'b0;
    if (!rd_en[p] || a == 0) return;
    for (int s = 0; s < 3; s++)
      if (stg_wen[s] && int'(stg_waddr[s*5 +: 5]) == a) begin
        d = stg_wvalid[s] ? stg_wdata[s*32 +: 32] : rf_rd_data[p*32 +: 32];
        h = !stg_wvalid[s];
        return;
      end
    d = rf_rd_data[p*32 +: 32];
    h = m_pend[a];
  endfunction
  function automatic bit exp_stall();
    logic [31:0] d;
    bit h0, h1;
    exp_port(0, d, h0);
    exp_port(1, d, h1);
    return h0 | h1;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0;
      m_cnt = 0;
    end else begin
      if (exp_stall() && !flush && m_cnt < 15) m_cnt++;
      if (flush) m_pend = '0;
      else begin
        if (lw_done) m_pend[lw_done_addr] = 1'b0;
        if (lw_issue && lw_issue_addr != 0) m_pend[lw_issue_addr] = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    logic [31:0] d0, d1;
    bit h0, h1;
    exp_port(0, d0, h0);
    exp_port(1, d1, h1);
    check("m_rd_data", rd_data, {d1, d0});
    check("m_hazard", 64'(hazard), 64'({h1, h0}));
    check("m_stall", 64'(stall), 64'(h0 | h1));
    check("m_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    check("m_rf_rd_addr", 64'(rf_rd_addr), 64'(rd_addr));
  end
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic settle();
    @(negedge clk);
    #1;
  endtask
  task automatic idle();
    rd_en = '0; rd_addr = '0; stg_wen = '0; stg_wvalid = '0; stg_waddr = '0; stg_wdata = '0;
    lw_issue = 0; lw_done = 0; flush = 0;
  endtask
  initial begin
    cyc(2);
    rst = 0;
    settle();
    check("reset_rd_data", rd_data, 64'h0);
    check("reset_hazard", 64'(hazard), 64'h0);
    check("reset_cnt", 64'(stall_cnt), 64'h0);
    cyc();
    stg_wen = 3'b111; stg_wvalid = 3'b111; stg_waddr = {5'd5, 5'd5, 5'd5};
    stg_wdata = {32'hC, 32'hB, 32'hA}; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    settle();
    check("prio_youngest", 64'(rd_data[31:0]), 64'hA);
    check("prio_no_stall", 64'(stall), 64'h0);
    cyc();
    stg_wen = 3'b110;
    settle();
    check("prio_next", 64'(rd_data[31:0]), 64'hB);
    cyc();
    idle();
    stg_wen = 3'b001; stg_waddr = {10'd0, 5'd7}; stg_wvalid = 3'b000; stg_wdata = 96'h5555;
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    settle();
    check("lu_hazard", 64'(hazard), 64'h2);
    check("lu_stall", 64'(stall), 64'h1);
    check("lu_cnt0", 64'(stall_cnt), 64'h0);
    cyc(3);
    settle();
    check("lu_cnt3", 64'(stall_cnt), 64'h3);
    cyc();
    idle();
    lw_issue = 1; lw_issue_addr = 5'd9;
    cyc();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9}; rf_rd_data = {32'h0, 32'h1234};
    settle();
    check("sb_hazard", 64'(hazard), 64'h1);
    cyc();
    lw_done = 1; lw_done_addr = 5'd9;
    settle();
    check("sb_done_same", 64'(hazard), 64'h1);
    cyc();
    lw_done = 0;
    settle();
    check("sb_done_after", 64'(hazard), 64'h0);
    check("sb_rf_data", 64'(rd_data[31:0]), 64'h1234);
    cyc();
    idle();
    lw_issue = 1; lw_issue_addr = 5'd12; lw_done = 1; lw_done_addr = 5'd12;
    cyc();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd12};
    settle();
    check("setclr_pending", 64'(hazard), 64'h1);
    cyc();
    flush = 1; lw_issue = 1; lw_issue_addr = 5'd3;
    cyc();
    idle();
    rd_en = 2'b11; rd_addr = {5'd3, 5'd12};
    settle();
    check("flush_clear", 64'(hazard), 64'h0);
    cyc();
    idle();
    stg_wen = 3'b001; stg_waddr = 15'd0; stg_wdata = 96'hFFFF; stg_wvalid = 3'b001;
    rd_en = 2'b01; rd_addr = 10'd0;
    settle();
    check("r0_data", 64'(rd_data[31:0]), 64'h0);
    check("r0_stall", 64'(stall), 64'h0);
    cyc();
    idle();
    lw_issue = 1; lw_issue_addr = 5'd20;
    cyc();
    idle();
    rd_addr = {5'd0, 5'd20}; rf_rd_data = {32'h0, 32'hBEEF};
    settle();
    check("rden0_data", 64'(rd_data[31:0]), 64'h0);
    check("rden0_hazard", 64'(hazard), 64'h0);
    cyc();
    rd_en = 2'b01;
    settle();
    check("pend20_hazard", 64'(hazard), 64'h1);
    cyc(20);
    settle();
    check("sat_cnt", 64'(stall_cnt), 64'hF);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    settle();
    check("rst_cnt", 64'(stall_cnt), 64'h0);
    check("rst_pending", 64'(hazard), 64'h0);
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bypass_scoreboard.md
# reg_bypass_scoreboard

Parametrised operand-forwarding and hazard unit for the integer pipeline: the multi-port, multi-stage successor to the single-port bypass mux. It serves NUM_READ decode-stage read ports. Each port forwards from NUM_STAGE in-flight writer stages, ordered youngest to oldest. A per-register scoreboard tracks long-latency writes, such as loads and multi-cycle ops, that no longer sit in a forwardable stage. The block drives a stall request and keeps a saturating hazard-stall counter for performance monitoring.

## Interface
- REG_WIDTH, 5, architectural register index width; NREGS = 2**REG_WIDTH
- DATA_WIDTH, 32, register data width
- NUM_READ, 2, number of decode read ports
- NUM_STAGE, 3, number of forwarding sources; index 0 = youngest (ex), NUM_STAGE-1 = oldest (wb)
- CNT_WIDTH, 32, stall counter width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; clears scoreboard next edge
- rd_en  in  NUM_READ  read request per port
- rd_addr  in  NUM_READ*REG_WIDTH  read index per port (port p at bits p*REG_WIDTH +: REG_WIDTH)
- rd_data  out  NUM_READ*DATA_WIDTH  resolved operand per port
- rf_rd_addr  out  NUM_READ*REG_WIDTH  passthrough of rd_addr to the register file
- rf_rd_data  in  NUM_READ*DATA_WIDTH  register-file read data
- stg_wen  in  NUM_STAGE  stage s holds a register write
- stg_waddr  in  NUM_STAGE*REG_WIDTH  destination index per stage
- stg_wdata  in  NUM_STAGE*DATA_WIDTH  result per stage
- stg_wvalid  in  NUM_STAGE  stg_wdata is final; 0 for a load or multi-cycle op whose result is not yet available
- lw_issue  in  1  a long-latency write leaves the forwarding window unresolved
- lw_issue_addr  in  REG_WIDTH  its destination
- lw_done  in  1  that long-latency result is written to the register file this cycle
- lw_done_addr  in  REG_WIDTH  its destination
- hazard  out  NUM_READ  per-port unresolved dependency
- stall  out  1  OR of hazard
- stall_cnt  out  CNT_WIDTH  saturating count of stalled cycles

## Operation
- Per port p, with a = rd_addr[p], resolve by priority:
  - rd_en[p]=0: rd_data=0, hazard=0.
  - a==0: rd_data=0, hazard=0. r0 never forwards and never stalls.
  - Otherwise, find the lowest s with stg_wen[s] & stg_waddr[s]==a. This is the youngest writer.
    - If that stage has stg_wvalid[s]=1: rd_data=stg_wdata[s], hazard=0.
    - If that stage has stg_wvalid[s]=0: rd_data=rf_rd_data[p] (don't-care), hazard=1. Older matching stages are ignored.
  - No stage match and pending[a]=1: hazard=1, rd_data=rf_rd_data[p].
  - No match, not pending: rd_data=rf_rd_data[p], hazard=0.
- Scoreboard pending[NREGS-1:0], pending[0] tied to 0:
  - lw_issue sets pending[lw_issue_addr] (ignored for index 0).
  - lw_done clears pending[lw_done_addr].
  - Same cycle, same address, set and clear together: set wins (new issue supersedes).
  - flush clears all bits and overrides lw_issue in the same cycle. lw_done for flushed ops is suppressed upstream.
  - Only one outstanding long-latency write per register. Upstream stalls a second issue via hazard on its own read or WAW check. Behaviour on a double set is a plain re-set.
- stall_cnt increments when stall=1 and flush=0, and saturates at all-ones.

## Timing
- Forwarding, hazard and stall are combinational from the current-cycle inputs and registered pending state; zero-cycle latency.
- Scoreboard updates are visible on the cycle after lw_issue, lw_done or flush.
- A lw_done in the same cycle as a read of that register: pending is still 1 and the register-file write is not yet readable, so hazard=1 this cycle. The next cycle reads the register file cleanly.
- Reset (rst=1 at edge): pending=0 and stall_cnt=0. With all inputs low after reset: rd_data=0, hazard=0, stall=0.
- rst mid-operation discards all pending entries. rst has priority over flush and lw_*.

## Test plan
- Priority: stg_wen=3'b111, all waddr=5, wdata={0xA,0xB,0xC} for s=0..2, wvalid all 1, read port0 addr 5 -> rd_data0=0xA, stall=0. Drop stg_wen[0] -> 0xB.
- Load-use: stg_wen[0]=1, waddr=7, wvalid=0, port1 reads 7 -> hazard=2'b10, stall=1, stall_cnt increments by 1 per cycle held.
- Scoreboard: lw_issue addr 9, then next cycle read 9 with no stage match -> hazard. Then lw_done addr 9 -> hazard still 1 that cycle, 0 the following cycle, rd_data=rf_rd_data.
- Same-cycle set/clear on addr 12, then flush with lw_issue addr 3 -> pending[12]=1 after first edge, all pending 0 after flush edge.
- r0 and rd_en: stg_wen[0]=1 waddr=0 wdata=0xFFFF, read 0 -> rd_data=0, no stall. rd_en=0 on a pending register -> rd_data=0, hazard=0.
- Saturation and reset: CNT_WIDTH=4, hold stall 20 cycles -> stall_cnt=15. Assert rst -> stall_cnt=0 and pending cleared next cycle.
